// File: rtl/letter_flow_pkg.sv
// Shared types and constants for the letter flow feeder: letter ranges,
// FSM states and the FIFO entry layout.
package letter_flow_pkg;

    localparam logic [7:0] UC_LO    = 8'h41;
    localparam logic [7:0] UC_HI    = 8'h5A;
    localparam logic [7:0] LC_LO    = 8'h61;
    localparam logic [7:0] LC_HI    = 8'h7A;
    localparam logic [7:0] CASE_BIT = 8'h20;

    typedef enum logic {
        RUN = 1'b0,
        GAP = 1'b1
    } state_t;

    typedef struct packed {
        logic       last;
        logic       is_letter;
        logic [7:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic is_letter_byte(input logic [7:0] b);
        return ((b >= UC_LO) && (b <= UC_HI)) || ((b >= LC_LO) && (b <= LC_HI));
    endfunction

endpackage

// File: rtl/letter_sync_fifo.sv
// Generic single-clock FIFO. Push is ignored when full and pop when empty;
// the head entry is presented combinationally on pop_data.
module letter_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/letter_flow_feeder.sv
// Buffers a raw ASCII stream, drops non-letters and emits one case-split
// letter per clock, with a filler gap after every message end.
module letter_flow_feeder
    import letter_flow_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter int         GAP_LEN  = 4,
    parameter logic [7:0] FILL_CAP = 8'h41,
    parameter logic [7:0] FILL_LOW = 8'h61
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  cap_flow,
    output logic [7:0]  low_flow,
    output logic        flow_vld,
    output logic [15:0] drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    entry_t          in_entry;
    entry_t          head;
    logic            byte_is_letter;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            unused_count;
    state_t          state, state_nxt;
    logic [7:0]      gap_cnt, gap_nxt;
    logic [7:0]      cap_nxt, low_nxt;
    logic            vld_nxt;

    assign byte_is_letter = is_letter_byte(in_data);
    assign in_ready       = !fifo_full;
    assign accept         = in_valid && in_ready;
    // Non-letters are only stored when they carry a message end.
    assign push           = accept && (byte_is_letter || in_last);
    assign in_entry       = '{last: in_last, is_letter: byte_is_letter, data: in_data};
    assign unused_count   = ^fifo_count;

    letter_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        cap_nxt   = FILL_CAP;
        low_nxt   = FILL_LOW;
        vld_nxt   = 1'b0;
        case (state)
            RUN: begin
                if (en && !fifo_empty) begin
                    pop = 1'b1;
                    if (head.is_letter) begin
                        cap_nxt = head.data & ~CASE_BIT;
                        low_nxt = head.data | CASE_BIT;
                        vld_nxt = 1'b1;
                    end
                    if (head.last) begin
                        state_nxt = GAP;
                        gap_nxt   = 8'(GAP_LEN);
                    end
                end
            end
            GAP: begin
                gap_nxt = gap_cnt - 8'd1;
                if (gap_cnt == 8'd1) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            gap_cnt  <= '0;
            cap_flow <= FILL_CAP;
            low_flow <= FILL_LOW;
            flow_vld <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            cap_flow <= cap_nxt;
            low_flow <= low_nxt;
            flow_vld <= vld_nxt;
            if (accept && !byte_is_letter && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule
